// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard unit: mux select codes,
// the per-stage destination entry, and the bubble constant.
package fwd_hazard_unit_pkg;

  localparam int RD_W = 5;
  localparam logic [RD_W-1:0] ZERO_REG_NUM = '0;

  // Operand-forwarding mux select codes (also used by the datapath muxes)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            le;
    logic            load;
  } stage_ent_t;

  // True when entry e produces register rs and that register is forwardable
  function automatic logic ent_hits(input stage_ent_t e,
                                    input logic [RD_W-1:0] rs,
                                    input logic [RD_W-1:0] zero_reg);
    return e.le && (e.rd != zero_reg) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Priority matcher for one source operand: youngest in-flight producer wins.
module fwd_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter logic [RD_W-1:0] ZERO_REG = ZERO_REG_NUM
) (
  input  logic [RD_W-1:0] rs,
  input  logic            used,
  input  stage_ent_t      ex_ent,
  input  stage_ent_t      mem_ent,
  input  stage_ent_t      wb_ent,
  output logic [1:0]      sel
);

  // Load flags only matter for the stall decision in the top
  logic unused_load;
  assign unused_load = ^{ex_ent.load, mem_ent.load, wb_ent.load};

  // Pick EX over MEM over WB; the zero register always reads the register file
  always_comb begin
    sel = FWD_RF;
    if (used && (rs != ZERO_REG)) begin
      if (ent_hits(ex_ent, rs, ZERO_REG)) begin
        sel = FWD_EX;
      end else if (ent_hits(mem_ent, rs, ZERO_REG)) begin
        sel = FWD_MEM;
      end else if (ent_hits(wb_ent, rs, ZERO_REG)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Destination-register tracker for EX/MEM/WB: forwarding selects,
// load-use stall and the WB register-file write port.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int              REG_W    = RD_W,
  parameter logic [REG_W-1:0] ZERO_REG = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rf_le,
  input  logic             id_load,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             load_use_stall,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_le
);

  // p0 = EX, p1 = MEM, p2 = WB
  stage_ent_t ent_p0_d, ent_p0_q;
  stage_ent_t ent_p1_d, ent_p1_q;
  stage_ent_t ent_p2_d, ent_p2_q;

  stage_ent_t bubble;
  logic       rs1_dep, rs2_dep;
  logic       stall;

  assign bubble = '{rd: ZERO_REG, le: 1'b0, load: 1'b0};

  // Load-use detection against the instruction currently in EX; flush wins
  always_comb begin
    rs1_dep = id_rs1_used && (id_rs1 != ZERO_REG) && (id_rs1 == ent_p0_q.rd);
    rs2_dep = id_rs2_used && (id_rs2 != ZERO_REG) && (id_rs2 == ent_p0_q.rd);
    stall   = ent_p0_q.le && ent_p0_q.load && (ent_p0_q.rd != ZERO_REG) &&
              (rs1_dep || rs2_dep) && !flush;
  end

  // Next stage contents: EX takes the ID entry unless stalled or flushed
  always_comb begin
    ent_p0_d = bubble;
    if (!flush && !stall) begin
      ent_p0_d.rd   = id_rd;
      ent_p0_d.le   = id_rf_le && (id_rd != ZERO_REG);
      ent_p0_d.load = id_load;
    end
    ent_p1_d = ent_p0_q;
    ent_p2_d = ent_p1_q;
  end

  // Stage registers; reset turns every stage into a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_p0_q <= bubble;
      ent_p1_q <= bubble;
      ent_p2_q <= bubble;
    end else begin
      ent_p0_q <= ent_p0_d;
      ent_p1_q <= ent_p1_d;
      ent_p2_q <= ent_p2_d;
    end
  end

  fwd_select #(.ZERO_REG(ZERO_REG)) u_sel_a (
    .rs      (id_rs1),
    .used    (id_rs1_used),
    .ex_ent  (ent_p0_q),
    .mem_ent (ent_p1_q),
    .wb_ent  (ent_p2_q),
    .sel     (fwd_a)
  );

  fwd_select #(.ZERO_REG(ZERO_REG)) u_sel_b (
    .rs      (id_rs2),
    .used    (id_rs2_used),
    .ex_ent  (ent_p0_q),
    .mem_ent (ent_p1_q),
    .wb_ent  (ent_p2_q),
    .sel     (fwd_b)
  );

  assign load_use_stall = stall;
  assign wb_rd          = ent_p2_q.rd;
  assign wb_le          = ent_p2_q.le;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus randomized traffic,
// all checked against a history-of-issued-instructions model.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_rf_le, id_load, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       load_use_stall;
  logic [4:0] wb_rd;
  logic       wb_le;

  int n_cmp;
  int n_bad;

  fwd_hazard_unit dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_rd          (id_rd),
    .id_rf_le       (id_rf_le),
    .id_load        (id_load),
    .flush          (flush),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .load_use_stall (load_use_stall),
    .wb_rd          (wb_rd),
    .wb_le          (wb_le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what entered the pipe 1, 2 and 3 cycles ago (index 0 = youngest)
  typedef struct {
    int rd;
    bit wr;
    bit ld;
  } slot_t;

  slot_t hist[3];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Distance to the youngest writer of rs (1..3), 0 if none or not applicable
  function automatic int exp_fwd(input int rs, input bit used);
    if (!used || rs == 0) return 0;
    for (int age = 0; age < 3; age++) begin
      if (hist[age].wr && hist[age].rd == rs) return age + 1;
    end
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit dep;
    if (flush) return 1'b0;
    if (!(hist[0].wr && hist[0].ld)) return 1'b0;
    dep = (id_rs1_used && id_rs1 != 0 && int'(id_rs1) == hist[0].rd) ||
          (id_rs2_used && id_rs2 != 0 && int'(id_rs2) == hist[0].rd);
    return dep;
  endfunction

  task automatic model_step();
    slot_t nxt;
    if (reset) begin
      for (int i = 0; i < 3; i++) hist[i] = '{rd: 0, wr: 1'b0, ld: 1'b0};
    end else begin
      if (flush || exp_stall()) nxt = '{rd: 0, wr: 1'b0, ld: 1'b0};
      else nxt = '{rd: int'(id_rd), wr: (id_rf_le && id_rd != 0), ld: id_load};
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = nxt;
    end
  endtask

  task automatic drive(input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit le, input bit ld, input bit fl,
                       input bit rst);
    id_rs1      = 5'(rs1);
    id_rs1_used = u1;
    id_rs2      = 5'(rs2);
    id_rs2_used = u2;
    id_rd       = 5'(rd);
    id_rf_le    = le;
    id_load     = ld;
    flush       = fl;
    reset       = rst;
  endtask

  // Check every output against the model mid-cycle, then clock and advance the model
  task automatic cycle();
    @(negedge clk);
    chk("fwd_a", int'(fwd_a), exp_fwd(int'(id_rs1), id_rs1_used));
    chk("fwd_b", int'(fwd_b), exp_fwd(int'(id_rs2), id_rs2_used));
    chk("stall", int'(load_use_stall), int'(exp_stall()));
    chk("wb_rd", int'(wb_rd), hist[2].rd);
    chk("wb_le", int'(wb_le), int'(hist[2].wr));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input bit rst);
    drive(0, 0, 0, 0, 0, 0, 0, 0, rst);
  endtask

  initial begin
    bit hold;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 3; i++) hist[i] = '{rd: 0, wr: 1'b0, ld: 1'b0};

    // Reset, then a short idle so the model and DUT start from bubbles
    idle(1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle(1'b0);
    #1;
    chk("rst_fwd_a", int'(fwd_a), 0);
    chk("rst_stall", int'(load_use_stall), 0);
    chk("rst_wb_le", int'(wb_le), 0);
    chk("rst_wb_rd", int'(wb_rd), 0);

    // Back-to-back ALU dependency on r5
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0); cycle();
    drive(5, 1, 6, 1, 0, 0, 0, 0, 0); #1;
    chk("b2b_fwd_a", int'(fwd_a), 1);
    chk("b2b_fwd_b", int'(fwd_b), 0);
    chk("b2b_stall", int'(load_use_stall), 0);
    cycle();

    // Distance 2 and 3 on r7, then its WB write
    drive(0, 0, 0, 0, 7, 1, 0, 0, 0); cycle();
    idle(1'b0); cycle();
    drive(7, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("dist2_fwd_a", int'(fwd_a), 2);
    cycle();
    drive(0, 0, 7, 1, 0, 0, 0, 0, 0); #1;
    chk("dist3_fwd_b", int'(fwd_b), 3);
    chk("dist3_wb_rd", int'(wb_rd), 7);
    chk("dist3_wb_le", int'(wb_le), 1);
    cycle();
    drive(7, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("dist4_fwd_a", int'(fwd_a), 0);
    cycle();

    // Load-use on r3 via rs2: one stall cycle, then MEM forwarding
    drive(0, 0, 0, 0, 3, 1, 1, 0, 0); cycle();
    drive(0, 0, 3, 1, 0, 0, 0, 0, 0); #1;
    chk("lu_stall", int'(load_use_stall), 1);
    cycle();
    #1;
    chk("lu_stall_end", int'(load_use_stall), 0);
    chk("lu_fwd_b", int'(fwd_b), 2);
    cycle();

    // Priority: r9 in EX and MEM picks EX; r0 write never forwards or writes
    drive(0, 0, 0, 0, 9, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 9, 1, 0, 0, 0); cycle();
    drive(9, 1, 0, 0, 0, 1, 0, 0, 0); #1;
    chk("prio_fwd_a", int'(fwd_a), 1);
    cycle();
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0); #1;
    chk("r0_fwd_a", int'(fwd_a), 0);
    chk("r0_fwd_b", int'(fwd_b), 0);
    cycle();
    idle(1'b0); cycle(); cycle();

    // Flush beats stall; unused operand never stalls
    drive(0, 0, 0, 0, 4, 1, 1, 0, 0); cycle();
    drive(4, 1, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("flush_stall", int'(load_use_stall), 0);
    cycle();
    drive(0, 0, 0, 0, 4, 1, 1, 0, 0); cycle();
    drive(4, 0, 4, 0, 0, 0, 0, 0, 0); #1;
    chk("unused_stall", int'(load_use_stall), 0);
    cycle();

    // Reset with three writers in flight
    drive(0, 0, 0, 0, 10, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 11, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 12, 1, 0, 0, 0); cycle();
    drive(12, 1, 0, 0, 0, 0, 0, 1, 1); cycle();
    drive(10, 1, 11, 1, 0, 0, 0, 0, 0); #1;
    chk("post_rst_fwd_a", int'(fwd_a), 0);
    chk("post_rst_fwd_b", int'(fwd_b), 0);
    chk("post_rst_wb_le", int'(wb_le), 0);
    cycle();

    // Randomized traffic over a small register set to force collisions;
    // ID inputs are held while the model expects a stall
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        drive(int'($urandom_range(0, 7)), bit'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 7)), bit'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 7)), bit'($urandom_range(0, 4) != 0),
              bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 9) == 0),
              bit'($urandom_range(0, 39) == 0));
      end
      hold = exp_stall() && !reset;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
